banked_main_mem: RTL
====================

Name: banked_main_mem

Overview:
- Four-bank, word-interleaved main memory that sits directly downstream of the cache controller FSM.
- Consumes its `addr`/`wr`/`rd`/`data_in` line-fill and writeback requests.
- Returns read data after a fixed 2-cycle latency.
- Asserts `stall` when the addressed bank is still busy from a prior access.
- Models the multi-cycle DRAM the cache refills from.

Parameters:
- ADDR_W, 16: byte-address width; storage holds 2^(ADDR_W-1) 16-bit words.
- BANK_BUSY, 4: cycles a bank stays busy after an accepted access, counting the accept cycle.
- RD_LAT, 2: cycles from accepted read to `data_out` valid.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- addr, input, ADDR_W: byte address; bank = addr[2:1]; word index = addr[ADDR_W-1:1].
- data_in, input, 16: write data.
- wr, input, 1: write request.
- rd, input, 1: read request.
- data_out, output, 16: read data, valid RD_LAT cycles after an accepted read.
- rd_valid, output, 1: high in exactly the cycle `data_out` carries accepted-read data.
- stall, output, 1: combinational; the request this cycle is rejected and must be held.
- busy, output, 4: per-bank busy flags, bit i = bank i.
- err, output, 1: illegal request this cycle.
- conflict_cnt, output, 16: stall-cycle counter (see Optional Feature).

Behaviour:
- **Reset:** `rst` sampled high clears all bank busy counters, the read pipeline, `rd_valid` and `conflict_cnt`.
  - Outputs after reset: `data_out`=0, `rd_valid`=0, `busy`=0, `stall`=0, `err`=0.
  - Memory contents are not cleared.
- **Request:** a request is `req = rd | wr` with `err=0`.
- **Error conditions:** `err=1` combinationally when `rd & wr`, or when `req` and `addr[0]=1`.
  - An erroring request is never accepted and has no side effects.
  - `stall` stays 0 for an erroring request.
- **Stall:** `stall = req & busy[addr[2:1]]`.
  - Stalled requests are dropped.
  - The requester must hold `addr`/`data`/`rd`/`wr` until `stall=0`.
- **Accept:** accept = `req & ~stall`. On an accepted cycle T:
  - The bank's busy counter loads BANK_BUSY-1 = 3.
  - The bank is busy in cycles T+1..T+3; a same-bank request at T+4 is accepted.
- **Bank counter:** each bank has a 2-bit down-counter; `busy[i] = (cnt_i != 0)`. Counters decrement each cycle while nonzero.
- **Write:** the memory word is updated at the end of cycle T.
- **Read:** the word is captured at the end of cycle T and travels through a 2-stage register pipeline.
  - `rd_valid`=1 and `data_out` = word in cycle T+2.
  - Otherwise `rd_valid`=0 and `data_out` holds its last value.
- **Throughput:** accesses to different banks may be accepted on consecutive cycles.
  - Four sequential words (offsets 0, 2, 4, 6) are accepted in four consecutive cycles with no stall.
  - Their data returns in cycles T+2 through T+5.
- **Same-address ordering:** a read accepted at T sees all writes accepted before T.
  - A same-address write cannot be accepted within T+1..T+3 (same bank), so there is no hazard.
- **Reset mid-operation:** the pending read pipeline is flushed.
  - No `rd_valid` is produced for reads accepted before reset.
  - A write accepted in the same cycle reset is high is discarded.
- **Idle behaviour:** with `rd=wr=0`, `stall`=0 and `err`=0 regardless of `busy`.

Optional Feature:
- Macro: BANKED_MEM_CONFLICT_CNT_EN.
- **Defined:** `conflict_cnt` increments by 1 on every cycle with `stall=1`.
  - It saturates at 16'hFFFF.
  - It is cleared by `rst`.
- **Undefined:** `conflict_cnt` is tied to 16'h0000 and no counter flops are built.

Test Plan:
- **Sequential fill:** write 0x1111/0x2222/0x3333/0x4444 to 0x0A00/0x0A02/0x0A04/0x0A06 on consecutive cycles -> `stall`=0 throughout. Then read the same four addresses back-to-back -> `rd_valid` in cycles T+2..T+5 with data 0x1111, 0x2222, 0x3333, 0x4444.
- **Bank conflict:** read 0x0100 at T, then request 0x0108 (same bank 0) at T+1 -> `stall`=1 at T+1, T+2, T+3; accepted at T+4, `data_out` valid at T+6. With the macro defined, `conflict_cnt`=3.
- **Illegal requests:** `rd=wr=1` at 0x0200 -> `err`=1, `stall`=0, no `rd_valid`, memory unchanged. `rd=1` at 0x0201 -> `err`=1.
- **Reset mid-read:** accept a read at T, assert `rst` at T+1 -> `rd_valid`=0 at T+2, `busy`=0 at T+2.
- **Read-after-write:** write 0xBEEF to 0x3002 at T, then read 0x3002 at T+4 -> `stall`=0, `data_out`=0xBEEF at T+6.
- **Disjoint banks:** simultaneous busy bank 1 (read 0x0002) followed next cycle by bank 2 (read 0x0004) -> both accepted, `busy`=4'b0110 at T+2.

Source files
------------

// File: rtl/banked_main_mem_if.sv
// banked_main_mem_if: request/response bus between the cache controller and banked main memory.
interface banked_main_mem_if #(parameter int ADDR_W = 16);
   logic [ADDR_W-1:0] addr;
   logic [15:0]       data_in;
   logic              wr;
   logic              rd;
   logic [15:0]       data_out;
   logic              rd_valid;
   logic              stall;
   logic [3:0]        busy;
   logic              err;
   logic [15:0]       conflict_cnt;
   modport master (output addr, data_in, wr, rd,
                   input  data_out, rd_valid, stall, busy, err, conflict_cnt);
   modport slave  (input  addr, data_in, wr, rd,
                   output data_out, rd_valid, stall, busy, err, conflict_cnt);
endinterface

// File: rtl/banked_main_mem.sv
// banked_main_mem: four-bank word-interleaved memory with fixed read latency and per-bank busy stalls.
// Define BANKED_MEM_CONFLICT_CNT_EN to build the saturating stall-cycle counter.
module banked_main_mem #(
   parameter int ADDR_W    = 16,
   parameter int BANK_BUSY = 4,
   parameter int RD_LAT    = 2
) (
   input logic              clk,
   input logic              rst,
   banked_main_mem_if.slave bus
);
   logic [15:0]       mem  [2**(ADDR_W-1)];
   logic [15:0]       pipe [RD_LAT];
   logic [RD_LAT-1:0] vld;
   logic [1:0]        cnt  [4];
   logic [3:0]        busy;
   logic [1:0]        bank;
   logic [ADDR_W-2:0] widx;
   logic              req, err, stall, acc;

   always_comb begin
      bank  = bus.addr[2:1];
      widx  = bus.addr[ADDR_W-1:1];
      err   = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
      req   = (bus.rd | bus.wr) & ~err;
      for (int i = 0; i < 4; i++) busy[i] = cnt[i] != 2'd0;
      stall = req & busy[bank];
      acc   = req & ~stall;
   end

   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < 4; i++) cnt[i] <= '0;
      else for (int i = 0; i < 4; i++)
         cnt[i] <= (acc && bank == 2'(i)) ? 2'(BANK_BUSY - 1) : cnt[i] - 2'(busy[i]);

   // a write coinciding with reset is dropped
   always_ff @(posedge clk)
      if (acc & bus.wr & ~rst) mem[widx] <= bus.data_in;

   // stages only advance on valid data so data_out holds the last returned word
   always_ff @(posedge clk)
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         vld <= RD_LAT'({vld, acc & bus.rd});
         if (acc & bus.rd) pipe[0] <= mem[widx];
         for (int i = 1; i < RD_LAT; i++) if (vld[i-1]) pipe[i] <= pipe[i-1];
      end

   assign bus.err      = err;
   assign bus.stall    = stall;
   assign bus.busy     = busy;
   assign bus.rd_valid = vld[RD_LAT-1];
   assign bus.data_out = pipe[RD_LAT-1];

`ifdef BANKED_MEM_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
   always_ff @(posedge clk)
      if (rst) conflict_cnt <= '0;
      else if (stall && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
   assign bus.conflict_cnt = conflict_cnt;
`else
   assign bus.conflict_cnt = 16'h0000;
`endif
endmodule
